// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants and FSM encoding for the two-requester
// register-file arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address / data widths
//   NUM_REQ                 : requester count (fixed at 2)
//   state_e                 : IDLE / ACCESS state encoding
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int NUM_REQ    = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side bus of ram_arbiter.
//   req_valid/req_we [NUM_REQ]           : request and write enable per requester
//   req_addr/req_wdata [NUM_REQ][W]      : per-requester address / write data
//   req_ready [NUM_REQ]                  : accept, one-hot or zero
//   rsp_valid [NUM_REQ], rsp_rdata [DATA_W] : completion pulse and data
// master = requester side, slave = arbiter side.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant logic.
//   clk, rst : clock, synchronous active-low reset
//   req[2]   : request bits
//   en       : arbitration allowed this cycle (arbiter idle, not in reset)
//   gnt[2]   : combinational one-hot grant, zero when !en or no request
// Build option RAM_ARB_RR_EN: defined -> round-robin (last winner loses
// ties); undefined -> fixed priority, requester 0 wins ties.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
`ifdef RAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // last granted requester; reset to 1 so requester 0 wins the first tie
  logic last;
  logic fav1;

  assign fav1 = RR_EN & ~last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = fav1 ? 2'b10 : 2'b01;
      else      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)            last <= 1'b1;
    else if (en && |req) last <= gnt[1];
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one register file between two requesters.
// Each transaction takes two cycles: handshake in IDLE, one ACCESS cycle
// driving the register file, completion pulse in the following cycle
// (which may itself carry the next handshake).
//   clk, rst   : clock, synchronous active-low reset
//   bus        : ram_arbiter_if.slave (requests / ready / responses)
//   ram_we     : register-file write strobe
//   ram_addr   : register-file address
//   ram_din    : register-file write data
//   ram_dout   : register-file read data, combinational from ram_addr
// Build option RAM_ARB_RR_EN selects round-robin arbitration (see rr_arb2).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  state_e             state;
  logic               id_q;
  logic               we_q;
  logic [NUM_REQ-1:0] rsp_vld_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [NUM_REQ-1:0] gnt;
  logic               idle;
  logic               hs;
  logic               win;

  assign idle = (state == IDLE) && rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.req_valid),
    .en  (idle),
    .gnt (gnt)
  );

  assign bus.req_ready = gnt;
  assign hs            = |(bus.req_valid & gnt);
  assign win           = gnt[1];

  // Gating with rst kills a write whose ACCESS cycle coincides with reset,
  // so an aborted transaction never reaches the register file.
  assign ram_we        = we_q & rst;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_rdata = rsp_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      rsp_vld_q <= '0;
      case (state)
        IDLE: begin
          if (hs) begin
            state    <= ACCESS;
            id_q     <= win;
            we_q     <= bus.req_we[win];
            ram_addr <= bus.req_addr[win];
            ram_din  <= bus.req_wdata[win];
          end
        end
        ACCESS: begin
          state           <= IDLE;
          we_q            <= 1'b0;
          rsp_vld_q[id_q] <= 1'b1;
          rsp_data_q      <= we_q ? ram_din : ram_dout;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors with a response scoreboard. Stimulus
// pushes expected {rsp_valid, rsp_rdata} on each handshake; a negedge
// monitor pops and compares whenever rsp_valid is non-zero.
module tb_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [7:0] mem [32];

  int vectors     = 0;
  int miscompares = 0;
  logic [9:0] sb [$];

  ram_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // register-file model
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic we, input logic [4:0] a, input logic [7:0] d);
    bus.req_valid[id] = 1'b1;
    bus.req_we[id]    = we;
    bus.req_addr[id]  = a;
    bus.req_wdata[id] = d;
  endtask

  // monitor
  always @(negedge clk) begin
    if (bus.rsp_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got valid %b data %0h expected none", bus.rsp_valid, bus.rsp_rdata);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("rsp", {22'd0, bus.rsp_valid, bus.rsp_rdata}, {22'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_gnt [4];
    int k, cyc;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
`ifdef RAM_ARB_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // reset state; ready held low while in reset despite requests
    repeat (3) tick();
    chk("rst_ready",    bus.req_ready, 2'b00);
    chk("rst_ram_we",   ram_we,        1'b0);
    chk("rst_ram_addr", ram_addr,      5'd0);
    chk("rst_ram_din",  ram_din,       8'h00);
    chk("rst_rsp_vld",  bus.rsp_valid, 2'b00);
    chk("rst_rsp_data", bus.rsp_rdata, 8'h00);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    tick();

    // requester 0 write addr 4 = 0x02
    drive(0, 1'b1, 5'd4, 8'h02);
    #1 chk("wr_ready", bus.req_ready, 2'b01);
    sb.push_back({2'b01, 8'h02});
    tick();
    bus.req_valid = 2'b00;
    chk("wr_ram_we",   ram_we,        1'b1);
    chk("wr_ram_addr", ram_addr,      5'd4);
    chk("wr_ram_din",  ram_din,       8'h02);
    chk("acc_ready",   bus.req_ready, 2'b00);
    tick();
    chk("wr_we_off", ram_we, 1'b0);

    // requester 1 read addr 4
    drive(1, 1'b0, 5'd4, 8'h00);
    #1 chk("rd_ready", bus.req_ready, 2'b10);
    sb.push_back({2'b10, 8'h02});
    tick();
    bus.req_valid = 2'b00;
    chk("rd_ram_we",   ram_we,   1'b0);
    chk("rd_ram_addr", ram_addr, 5'd4);
    tick();

    // back-to-back: write addr 0 = 0x01 then read addr 0
    drive(0, 1'b1, 5'd0, 8'h01);
    #1 chk("b2b_ready1", bus.req_ready, 2'b01);
    sb.push_back({2'b01, 8'h01});
    tick();
    drive(0, 1'b0, 5'd0, 8'h00);
    #1 chk("b2b_acc_ready", bus.req_ready, 2'b00);
    tick();
    chk("b2b_coincide", {bus.rsp_valid, bus.req_ready}, 4'b0101);
    sb.push_back({2'b01, 8'h01});
    tick();
    bus.req_valid = 2'b00;
    chk("b2b_rd_addr", ram_addr, 5'd0);
    chk("b2b_rd_we",   ram_we,   1'b0);
    tick();

    // requester 1 pulses valid only during ACCESS: must be ignored
    drive(0, 1'b1, 5'd10, 8'h33);
    #1 chk("pulse_ready0", bus.req_ready, 2'b01);
    sb.push_back({2'b01, 8'h33});
    tick();
    bus.req_valid = 2'b00;
    drive(1, 1'b0, 5'd12, 8'h00);
    #1 chk("pulse_ready1", bus.req_ready, 2'b00);
    tick();
    bus.req_valid = 2'b00;
    repeat (3) tick();
    chk("pulse_addr", ram_addr, 5'd10);
    chk("pulse_we",   ram_we,   1'b0);

    // reset restores pointer and clears response data
    rst = 1'b0;
    tick();
    tick();
    chk("rst2_rsp_data", bus.rsp_rdata, 8'h00);
    chk("rst2_ram_addr", ram_addr,      5'd0);
    rst = 1'b1;
    tick();

    // contention: both valid continuously, req0 reads addr 4, req1 addr 0
    drive(0, 1'b0, 5'd4, 8'h00);
    drive(1, 1'b0, 5'd0, 8'h00);
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 20) begin
      #1;
      if (bus.req_ready !== 2'b00) begin
        chk($sformatf("grant_%0d", k), bus.req_ready, exp_gnt[k]);
        sb.push_back({exp_gnt[k], (exp_gnt[k] == 2'b01) ? 8'h02 : 8'h01});
        k++;
      end
      tick();
      cyc++;
    end
    if (k < 4) chk("grant_timeout", k, 4);
    bus.req_valid = 2'b00;
    repeat (3) tick();

    // reset during ACCESS of write addr 8 = 0x55: aborted
    drive(0, 1'b1, 5'd8, 8'h55);
    #1 chk("abort_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    rst = 1'b0;
    #1 chk("abort_we", ram_we, 1'b0);
    tick();
    chk("abort_rsp",  bus.rsp_valid, 2'b00);
    chk("abort_addr", ram_addr,      5'd0);
    rst = 1'b1;
    tick();
    drive(1, 1'b0, 5'd8, 8'h00);
    #1 chk("abort_rd_ready", bus.req_ready, 2'b10);
    sb.push_back({2'b10, 8'h00});
    tick();
    bus.req_valid = 2'b00;
    repeat (4) tick();

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
